pyrm_decode_block: RTL

- Decode stage directly downstream of the fetch stage.
- Accepts {pc, inst} pairs over a valid/retry handshake and buffers them in a 2-entry skid FIFO.
- Decodes the head entry into RV64I fields (register indices, sign-extended immediate, op class, flags) and presents the bundle to execute over a second valid/retry handshake.
- Full-throughput buffering decouples fetch from execute backpressure.

---
 rtl/pyrm_decode_block.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pyrm_decode_block.sv
// pyrm_decode_block
// Decode stage sitting directly behind fetch. Incoming {pc, inst} pairs are
// held in a 2-entry skid FIFO. The head entry is decoded into RV64I fields
// and offered to execute. Because the FIFO has two entries, fetch can keep
// streaming at full rate even though execute may stall.
//
// Ports:
//   clk, reset_pyri (async, active-low), flush_pyri (sync flush)
//   upstream   : pc_pyri, inst_pyri, inst_valid_pyri -> inst_retry_pyro
//   downstream : dec_* bundle, dec_valid_pyro <- dec_retry_pyri
//   A transfer happens when valid is high and retry is low in the same cycle.
module pyrm_decode_block #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset_pyri,
  input  logic              flush_pyri,
  input  logic [PC_W-1:0]   pc_pyri,
  input  logic [INST_W-1:0] inst_pyri,
  input  logic              inst_valid_pyri,
  output logic              inst_retry_pyro,
  output logic [PC_W-1:0]   dec_pc_pyro,
  output logic [4:0]        dec_rd_pyro,
  output logic [4:0]        dec_rs1_pyro,
  output logic [4:0]        dec_rs2_pyro,
  output logic [2:0]        dec_funct3_pyro,
  output logic [6:0]        dec_funct7_pyro,
  output logic [PC_W-1:0]   dec_imm_pyro,
  output logic [3:0]        dec_class_pyro,
  output logic              dec_rd_we_pyro,
  output logic              dec_is_branch_pyro,
  output logic              dec_illegal_pyro,
  output logic              dec_valid_pyro,
  input  logic              dec_retry_pyri
);

  localparam logic [3:0] CLS_OP      = 4'd0;
  localparam logic [3:0] CLS_OPIMM   = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_LUI     = 4'd7;
  localparam logic [3:0] CLS_AUIPC   = 4'd8;
  localparam logic [3:0] CLS_OP32    = 4'd9;
  localparam logic [3:0] CLS_OPIMM32 = 4'd10;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  // FIFO storage and control
  logic [PC_W-1:0]   pc_mem   [2];
  logic [INST_W-1:0] inst_mem [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;
  logic [1:0]        count_next;
  logic              retry_reg;

  logic push;
  logic pop;

  assign push = inst_valid_pyri & ~retry_reg;
  assign pop  = (count_reg != 2'd0) & ~dec_retry_pyri;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Retry is registered from the next count so fetch sees a clean flop
  // output; it is high exactly while both entries are occupied.
  always_ff @(posedge clk or negedge reset_pyri) begin
    if (!reset_pyri) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      retry_reg  <= 1'b0;
    end else if (flush_pyri) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
      retry_reg  <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
      retry_reg <= (count_next == 2'd2);
    end
  end

  // Storage needs no reset: entries are only observed while count says valid.
  always_ff @(posedge clk) begin
    if (push && !flush_pyri) begin
      pc_mem[wr_ptr_reg]   <= pc_pyri;
      inst_mem[wr_ptr_reg] <= inst_pyri;
    end
  end

  assign inst_retry_pyro = retry_reg;
  assign dec_valid_pyro  = (count_reg != 2'd0);

  // Decode of the head entry
  logic [INST_W-1:0] head_inst;
  logic [3:0]        cls;
  logic [PC_W-1:0]   imm;

  assign head_inst       = inst_mem[rd_ptr_reg];
  assign dec_pc_pyro     = pc_mem[rd_ptr_reg];
  assign dec_rd_pyro     = head_inst[11:7];
  assign dec_rs1_pyro    = head_inst[19:15];
  assign dec_rs2_pyro    = head_inst[24:20];
  assign dec_funct3_pyro = head_inst[14:12];
  assign dec_funct7_pyro = head_inst[31:25];

  always_comb begin
    cls = CLS_ILLEGAL;
    case (head_inst[6:0])
      7'b0110011: cls = CLS_OP;
      7'b0010011: cls = CLS_OPIMM;
      7'b0000011: cls = CLS_LOAD;
      7'b0100011: cls = CLS_STORE;
      7'b1100011: cls = CLS_BRANCH;
      7'b1101111: cls = CLS_JAL;
      7'b1100111: cls = CLS_JALR;
      7'b0110111: cls = CLS_LUI;
      7'b0010111: cls = CLS_AUIPC;
      7'b0111011: cls = CLS_OP32;
      7'b0011011: cls = CLS_OPIMM32;
      default:    cls = CLS_ILLEGAL;
    endcase
  end

  // Every immediate format sign-extends from inst[31].
  always_comb begin
    imm = '0;
    case (cls)
      CLS_OPIMM, CLS_OPIMM32, CLS_LOAD, CLS_JALR:
        imm = {{(PC_W-12){head_inst[31]}}, head_inst[31:20]};
      CLS_STORE:
        imm = {{(PC_W-12){head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
      CLS_BRANCH:
        imm = {{(PC_W-13){head_inst[31]}}, head_inst[31], head_inst[7],
               head_inst[30:25], head_inst[11:8], 1'b0};
      CLS_LUI, CLS_AUIPC:
        imm = {{(PC_W-32){head_inst[31]}}, head_inst[31:12], 12'b0};
      CLS_JAL:
        imm = {{(PC_W-21){head_inst[31]}}, head_inst[31], head_inst[19:12],
               head_inst[20], head_inst[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

  assign dec_class_pyro     = cls;
  assign dec_imm_pyro       = imm;
  assign dec_illegal_pyro   = (cls == CLS_ILLEGAL);
  assign dec_is_branch_pyro = (cls == CLS_BRANCH) | (cls == CLS_JALR);
  // Writes to x0 are suppressed here so execute never has to check rd.
  assign dec_rd_we_pyro     = (cls != CLS_STORE) && (cls != CLS_BRANCH) &&
                              (cls != CLS_ILLEGAL) && (head_inst[11:7] != 5'd0);

endmodule
